// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer: FSM state codes, MAC_Unit command
// encodings and the result width.
package mac_seq_pkg;

    localparam int RES_W = 8;

    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t CLEAR = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t DRAIN = 3'd3;
    localparam state_t DONE  = 3'd4;

    typedef logic [1:0] mac_cmd_t;
    localparam mac_cmd_t MAC_HOLD = 2'b00;
    localparam mac_cmd_t MAC_CLR  = 2'b01;
    localparam mac_cmd_t MAC_ACC  = 2'b10;

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand stream (valid/ready) and result port (valid/ready + sticky wrap flag)
// of the MAC sequencer. The sequencer is the slave on both.
interface mac_sequencer_if;
    import mac_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_a;
    logic [1:0]       in_b;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, result, overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, result, overflow
    );

endinterface

// File: rtl/mac_ovf_detect.sv
// Tracks the MAC accumulator after every accumulate and raises a sticky flag
// the first time it wraps (new value smaller than the previous one).
module mac_ovf_detect
    import mac_seq_pkg::*;
#(
    parameter int MAC_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             acc,
    input  logic [RES_W-1:0] mac_Y,
    output logic             ovf
);

    logic [MAC_LAT-1:0] dly;
    logic [RES_W-1:0]   prev_y;
    logic               chk;

    // The oldest tap lines up with the cycle in which mac_Y shows that accumulate.
    assign chk = dly[MAC_LAT-1];

    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            dly    <= '0;
            prev_y <= '0;
            ovf    <= 1'b0;
        end else begin
            dly <= MAC_LAT'({dly, acc});
            if (chk) begin
                if (mac_Y < prev_y)
                    ovf <= 1'b1;
                prev_y <= mac_Y;
            end
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Runs one dot-product job on the 2-bit MAC_Unit: clear, stream len pairs,
// wait for the pipeline, then hold the 8-bit sum on a valid/ready port.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int LEN_W   = 6,
    parameter int MAC_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    mac_sequencer_if.slave   io,
    output logic [1:0]       mac_I,
    output logic [1:0]       mac_A,
    output logic [1:0]       mac_B,
    output logic             mac_S,
    input  logic [RES_W-1:0] mac_Y,
    output logic             busy
);

    localparam int DRAIN_W = $clog2(MAC_LAT + 2);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               hs;
    logic               job_go;
    logic               acc_issued;

    assign job_go     = (state == IDLE) && start;
    assign acc_issued = (mac_I == MAC_ACC);

    always_comb begin
        // NOTE: every signal written here gets a value before the case, so no path leaves it unassigned and no latch is inferred.
        hs        = (state == RUN) && io.in_ready && io.in_valid;
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (remaining == '0) ? DRAIN : RUN;
            RUN:     if (hs && remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
            DONE:    if (io.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a register loaded from next-state decode, so no input reaches an output combinationally.
    always_ff @(posedge CLK) begin
        // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
        if (!RST_N) begin
            state        <= IDLE;
            remaining    <= '0;
            drain_cnt    <= '0;
            busy         <= 1'b0;
            mac_I        <= MAC_HOLD;
            mac_A        <= '0;
            mac_B        <= '0;
            mac_S        <= 1'b0;
            io.in_ready  <= 1'b0;
            io.res_valid <= 1'b0;
            io.result    <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != IDLE);
            io.in_ready  <= (state_nxt == RUN);
            io.res_valid <= (state_nxt == DONE);
            mac_S        <= (state_nxt == DONE);

            if (job_go)
                remaining <= len;
            else if (hs)
                remaining <= remaining - LEN_W'(1);

            // DRAIN counts MAC_LAT+1 hold cycles after the final accumulate cycle.
            if (state_nxt == DRAIN && state != DRAIN)
                drain_cnt <= DRAIN_W'(MAC_LAT + 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DRAIN_W'(1);

            if (state_nxt == CLEAR)
                mac_I <= MAC_CLR;
            else if (hs)
                mac_I <= MAC_ACC;
            else
                mac_I <= MAC_HOLD;

            if (hs) begin
                mac_A <= io.in_a;
                mac_B <= io.in_b;
            end

            if (state == DRAIN && state_nxt == DONE)
                io.result <= mac_Y;
        end
    end

    mac_ovf_detect #(
        .MAC_LAT (MAC_LAT)
    ) u_ovf_detect (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (job_go),
        .acc   (acc_issued),
        .mac_Y (mac_Y),
        .ovf   (io.overflow)
    );

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC_Unit, handshake monitor and a
// sum-of-products reference model driven by directed and $urandom jobs.
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    localparam int LEN_W   = 6;
    localparam int MAC_LAT = 1;

    logic             CLK   = 1'b0;
    logic             RST_N = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic [1:0]       mac_I;
    logic [1:0]       mac_A;
    logic [1:0]       mac_B;
    logic             mac_S;
    logic [7:0]       mac_Y;
    logic             busy;

    mac_sequencer_if io();

    int n_checks = 0;
    int n_errors = 0;

    // Monitor tallies; only the monitor writes them, jobs compare deltas.
    int acc_cnt  = 0;
    int clr_cnt  = 0;
    int rdy_cnt  = 0;
    int rv_cnt   = 0;
    int bad_pair = 0;
    int bad_cmd  = 0;
    logic [3:0] hs_q[$];

    int pa[$];
    int pb[$];

    // MAC_Unit model (MAC_LAT = 1); powers up non-zero and is never reset.
    logic [7:0] mac_acc = 8'hA5;

    always #5 CLK = ~CLK;

    mac_sequencer #(
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (start),
        .len   (len),
        .io    (io),
        .mac_I (mac_I),
        .mac_A (mac_A),
        .mac_B (mac_B),
        .mac_S (mac_S),
        .mac_Y (mac_Y),
        .busy  (busy)
    );

    always @(posedge CLK) begin
        if (mac_I == MAC_CLR)
            mac_acc <= 8'h00;
        else if (mac_I == MAC_ACC)
            mac_acc <= mac_acc + 8'(mac_A) * 8'(mac_B);
    end
    assign mac_Y = mac_acc;

    always @(posedge CLK) begin
        if (RST_N) begin
            if (mac_I == MAC_CLR) begin
                clr_cnt++;
                hs_q.delete();
            end
            if (io.in_valid && io.in_ready)
                hs_q.push_back({io.in_a, io.in_b});
            if (mac_I == MAC_ACC) begin
                acc_cnt++;
                if (hs_q.size() == 0 || hs_q[0] != {mac_A, mac_B})
                    bad_pair++;
                if (hs_q.size() > 0)
                    void'(hs_q.pop_front());
            end
            if (mac_I == 2'b11)
                bad_cmd++;
            if (io.in_ready)
                rdy_cnt++;
            if (io.res_valid)
                rv_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode: 0 back-to-back, 1 valid toggles 1/0, 2 random bubbles.
    task automatic run_job(input string tag, input int mode, input int stall, input bit poke);
        int n, idx, cyc, sum;
        int acc0, clr0, rdy0, rv0, bad0;
        bit v, rdy, stable;
        logic [7:0] res_hold;
        logic       ovf_hold;

        n   = pa.size();
        sum = 0;
        foreach (pa[i]) sum += pa[i] * pb[i];
        acc0 = acc_cnt;
        clr0 = clr_cnt;
        rdy0 = rdy_cnt;
        rv0  = rv_cnt;
        bad0 = bad_pair + bad_cmd;

        io.res_ready = (stall == 0);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        check({tag, "/clear"}, {busy, mac_I}, {1'b1, MAC_CLR});

        idx = 0;
        cyc = 0;
        do begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(1, 0));
            endcase
            if (idx < n) begin
                io.in_valid = v;
                io.in_a     = 2'(pa[idx]);
                io.in_b     = 2'(pb[idx]);
            end else begin
                io.in_valid = 1'($urandom_range(1, 0));
                io.in_a     = 2'($urandom);
                io.in_b     = 2'($urandom);
            end
            if (poke) begin
                start = 1'($urandom_range(1, 0));
                len   = LEN_W'($urandom);
            end
            rdy = io.in_ready;
            tick();
            cyc++;
            if (io.in_valid && rdy)
                idx++;
        end while (!io.res_valid && cyc < 600);
        start       = 1'b0;
        io.in_valid = 1'b0;

        if (!io.res_valid) begin
            check({tag, "/timeout"}, 32'd0, 32'd1);
            pa.delete();
            pb.delete();
            return;
        end

        if (mode == 0)
            check({tag, "/latency"}, cyc, n + MAC_LAT + 3);
        check({tag, "/pairs_taken"}, idx, n);
        check({tag, "/result"}, io.result, sum % 256);
        check({tag, "/overflow"}, io.overflow, sum >= 256);
        check({tag, "/done_flags"}, {io.res_valid, mac_S, busy, io.in_ready}, 4'b1110);

        stable   = 1'b1;
        res_hold = io.result;
        ovf_hold = io.overflow;
        for (int i = 0; i < stall; i++) begin
            start = 1'b1;
            tick();
            if (!io.res_valid || !mac_S || io.result != res_hold || io.overflow != ovf_hold)
                stable = 1'b0;
        end
        start = 1'b0;
        if (stall > 0)
            check({tag, "/hold_stable"}, stable, 1);

        io.res_ready = 1'b1;
        tick();
        check({tag, "/release"}, {io.res_valid, mac_S, busy}, 3'b000);

        io.res_ready = 1'($urandom_range(1, 0));
        tick();
        check({tag, "/idle"}, {busy, io.res_valid, mac_I}, {2'b00, MAC_HOLD});
        io.res_ready = 1'b0;

        check({tag, "/acc_cmds"}, acc_cnt - acc0, n);
        check({tag, "/clr_cmds"}, clr_cnt - clr0, 1);
        check({tag, "/pair_order"}, bad_pair + bad_cmd - bad0, 0);
        check({tag, "/res_valid_cycles"}, rv_cnt - rv0, stall + 1);
        if (mode == 0)
            check({tag, "/in_ready_cycles"}, rdy_cnt - rdy0, n);

        pa.delete();
        pb.delete();
    endtask

    task automatic reset_mid_job();
        int idx, cyc;
        bit rdy;
        io.res_ready = 1'b1;
        start = 1'b1;
        len   = LEN_W'(5);
        tick();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 2 && cyc < 50) begin
            io.in_valid = 1'b1;
            io.in_a     = 2'($urandom);
            io.in_b     = 2'($urandom);
            rdy = io.in_ready;
            tick();
            cyc++;
            if (rdy)
                idx++;
        end
        check("rst_mid/two_pairs", idx, 2);
        // A third pair stays offered while reset is low; it must be discarded.
        io.in_a = 2'd3;
        io.in_b = 2'd3;
        RST_N   = 1'b0;
        tick();
        check("rst_mid/state", {busy, io.res_valid, io.in_ready, mac_S, mac_I}, 6'b0);
        RST_N       = 1'b1;
        io.in_valid = 1'b0;
        tick();
        check("rst_mid/stay_idle", {busy, mac_I}, {1'b0, MAC_HOLD});
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.res_ready = 1'b0;

        RST_N = 1'b0;
        repeat (2) tick();
        check("reset/ctrl", {busy, io.in_ready, io.res_valid, mac_S, mac_I}, 6'b0);
        check("reset/operands", {mac_A, mac_B}, 4'h0);
        check("reset/result", {io.overflow, io.result}, 9'h000);
        RST_N = 1'b1;
        tick();

        pa = '{1, 3, 3};
        pb = '{2, 1, 3};
        run_job("len3", 0, 0, 1'b0);

        run_job("len0", 0, 0, 1'b0);

        for (int i = 0; i < 29; i++) begin
            pa.push_back(3);
            pb.push_back(3);
        end
        run_job("len29_wrap", 0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            pa.push_back(2);
            pb.push_back(2);
        end
        run_job("len4_bubbles", 1, 5, 1'b0);

        reset_mid_job();
        pa = '{3};
        pb = '{2};
        run_job("after_reset", 0, 0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            pa.push_back(int'($urandom_range(3, 0)));
            pb.push_back(int'($urandom_range(3, 0)));
        end
        run_job("busy_start", 0, 0, 1'b1);

        for (int j = 0; j < 10; j++) begin
            int n;
            n = int'($urandom_range(63, 0));
            for (int i = 0; i < n; i++) begin
                pa.push_back(int'($urandom_range(3, 0)));
                pb.push_back(int'($urandom_range(3, 0)));
            end
            run_job($sformatf("rand%0d", j), int'($urandom_range(2, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that runs one dot-product job on the 2-bit-operand MAC_Unit: clears its accumulator, streams N operand pairs into it and returns the 8-bit sum.
- Sits between an operand source (valid/ready stream) and the MAC_Unit; owns the MAC's I, A, B and S pins.
- Result is presented on a valid/ready port with a sticky wrap (overflow) flag.

Parameters:
- LEN_W, 6, width of the job length field; max pairs per job = 2^LEN_W-1.
- MAC_LAT, 1, cycles from a MAC accumulate command (I=10) to the updated Y.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous reset, active-low.
- start  in  1  one-cycle job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; latched on an accepted start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_a  in  2  operand A.
- in_b  in  2  operand B.
- mac_I  out  2  MAC command: 00 hold, 01 clear accumulator, 10 accumulate A*B, 11 unused (never driven).
- mac_A  out  2  operand A to MAC.
- mac_B  out  2  operand B to MAC.
- mac_S  out  1  MAC output-enable; 1 only in DONE.
- mac_Y  in  8  MAC accumulator value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- result  out  8  captured dot product, modulo 256.
- overflow  out  1  accumulator wrapped at least once during the job.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N=0 at an edge): state=IDLE; all outputs 0; internal counters cleared. The MAC accumulator is not touched; the next job clears it.
- All outputs are registered. There is no combinational path from in_valid, start or res_ready to any output.
- IDLE: in_ready=0, mac_I=00. start=1 latches len into a counter and moves to CLEAR. in_valid is ignored.
- CLEAR (1 cycle): mac_I=01, mac_S=0, overflow cleared, prev_Y cleared to 0. Next state is RUN, or DRAIN when len==0.
- RUN:
  - in_ready=1 while the remaining count > 0.
  - A handshake at edge k registers in_a/in_b onto mac_A/mac_B and drives mac_I=10 for the cycle after edge k only. Otherwise mac_I=00 and mac_A/B hold.
  - Throughput is one pair per cycle; in_valid bubbles insert hold cycles.
  - The handshake that decrements the count to 0 also deasserts in_ready at that same edge and moves the state to DRAIN.
- DRAIN: waits MAC_LAT+1 cycles with mac_I=00 so that mac_Y reflects the last accumulate, then moves to DONE.
- Overflow detection: MAC_LAT cycles after each accumulate, compare mac_Y with prev_Y. If mac_Y < prev_Y, set overflow. Then prev_Y <= mac_Y. Products are at most 9, so a single wrap is always detectable.
- DONE:
  - On entry: result <= mac_Y, res_valid=1, mac_S=1.
  - result and overflow hold stable while res_valid=1 && res_ready=0.
  - On res_valid && res_ready: res_valid=0, mac_S=0, state=IDLE at that edge.
  - Earliest new start is the following cycle.
- Simultaneous events: start while busy is ignored, with no queueing. res_ready without res_valid is ignored.
- Reset mid-job, in any state: IDLE at that edge; res_valid and in_ready drop; the in-flight pair is discarded.
- Latency for len=N with no bubbles and res_ready=1: start edge → res_valid after N+MAC_LAT+3 cycles.

Decomposition:
- Package mac_seq_pkg:
  - state enum IDLE/CLEAR/RUN/DRAIN/DONE;
  - MAC command constants MAC_HOLD=2'b00, MAC_CLR=2'b01, MAC_ACC=2'b10;
  - result width constant 8.
- One sub-module, mac_ovf_detect: delay line of MAC_LAT for the accumulate strobe, plus the prev_Y comparator and sticky flag.

Test Plan:
- len=3, pairs (1,2),(3,1),(3,3) back-to-back, res_ready=1 → mac_I sequence 01,10,10,10; result=0x0E, overflow=0, res_valid high exactly 1 cycle.
- len=0, start → one CLEAR cycle, no in_ready; result=0x00, overflow=0.
- len=29, all pairs (3,3) → result=0x05 (261 mod 256), overflow=1.
- len=4, in_valid toggling 1/0 and pairs (2,2)x4 → mac_I=10 only on accepted pairs; result=0x10. Then hold res_ready=0 for 5 cycles → result/res_valid stable; start pulses during this window are ignored.
- len=5, RST_N=0 for 1 cycle after the 2nd pair → IDLE next edge, busy=0, res_valid=0. A new job len=1, (3,2) → result=0x06, proving the CLEAR step.
- start while busy mid-RUN with len=7 → original job completes unchanged; no second job starts.
